// File: rtl/moving_average_filter_if.sv
// ---------------------------------------------------------------------------
// moving_average_filter_if
// Streaming handshake bundle for the moving-average filter.
//   clear_i  : synchronous history/sum clear (active-high)
//   data_i   : input sample, valid_i / ready_o handshake
//   data_o   : averaged sample, valid_o / ready_i handshake
// Modports:
//   slave  : filter side (consumes data_i, produces data_o)
//   master : environment side (produces data_i, consumes data_o)
// ---------------------------------------------------------------------------
interface moving_average_filter_if #(
  parameter int width_p = 8
);
  logic               clear_i;
  logic [width_p-1:0] data_i;
  logic               valid_i;
  logic               ready_o;
  logic [width_p-1:0] data_o;
  logic               valid_o;
  logic               ready_i;

  modport slave (
    input  clear_i, data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o
  );

  modport master (
    output clear_i, data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o
  );
endinterface

// File: rtl/moving_average_filter.sv
// ---------------------------------------------------------------------------
// moving_average_filter
// N-tap boxcar low-pass filter, N = 2**depth_log2_p. Keeps a circular history
// of the last N accepted samples plus a running sum, and emits sum/N through a
// one-entry elastic output register (1 cycle latency, 1 sample/cycle).
//
// Ports:
//   clk_i    : clock, all state on posedge
//   reset_ni : asynchronous active-low reset (history, sum, output cleared)
//   bus      : moving_average_filter_if.slave
//                clear_i, data_i, valid_i, ready_i in
//                ready_o, data_o, valid_o           out
//
// Parameters:
//   width_p      : unsigned sample width (>= 2)
//   depth_log2_p : log2 of tap count (0..6; 0 = registered passthrough)
//
// Optional build macro:
//   MOVING_AVERAGE_ROUND_EN : round half up instead of truncating the divide.
// ---------------------------------------------------------------------------
module moving_average_filter #(
  parameter int width_p      = 8,
  parameter int depth_log2_p = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  moving_average_filter_if.slave  bus
);

  localparam int N     = 1 << depth_log2_p;
  localparam int SUM_W = width_p + depth_log2_p;
  localparam int PTR_W = (depth_log2_p > 0) ? depth_log2_p : 1;
  localparam int HALF  = N / 2;  // 0 when N == 1, so rounding is a no-op there

  logic [width_p-1:0] r_hist [N];
  logic [PTR_W-1:0]   r_wptr;
  logic [SUM_W-1:0]   r_sum;
  logic [width_p-1:0] r_data;
  logic               r_valid;

  logic               w_ready;
  logic               w_in_fire;
  logic               w_out_fire;
  logic [width_p-1:0] w_oldest;
  logic [SUM_W-1:0]   w_sum_next;
  logic [PTR_W-1:0]   w_wptr_next;

  // Divide the running sum by N. The rounding offset cannot overflow: the
  // largest sum is 2**SUM_W - N, and adding N/2 stays below 2**SUM_W.
  function automatic logic [width_p-1:0] scale_sum(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] t;
`ifdef MOVING_AVERAGE_ROUND_EN
    t = s + SUM_W'(HALF);
`else
    t = s;
`endif
    return width_p'(t >> depth_log2_p);
  endfunction

  // The output slot is free if empty or draining this cycle; a clear blocks
  // input so the history reset is never mixed with a new sample.
  assign w_ready    = (~r_valid | bus.ready_i) & ~bus.clear_i;
  assign w_in_fire  = bus.valid_i & w_ready;
  assign w_out_fire = r_valid & bus.ready_i;

  // The oldest sample is one of the terms of r_sum, so the modular
  // add/subtract below yields the exact new sum.
  assign w_oldest    = r_hist[r_wptr];
  assign w_sum_next  = r_sum + SUM_W'(bus.data_i) - SUM_W'(w_oldest);
  assign w_wptr_next = (depth_log2_p == 0) ? '0 : r_wptr + 1'b1;

  // History / running-sum stage
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < N; i++) r_hist[i] <= '0;
      r_wptr <= '0;
      r_sum  <= '0;
    end else if (bus.clear_i) begin
      for (int i = 0; i < N; i++) r_hist[i] <= '0;
      r_wptr <= '0;
      r_sum  <= '0;
    end else if (w_in_fire) begin
      r_hist[r_wptr] <= bus.data_i;
      r_wptr         <= w_wptr_next;
      r_sum          <= w_sum_next;
    end
  end

  // Elastic output register stage
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_data  <= scale_sum(w_sum_next);
      r_valid <= 1'b1;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.ready_o = w_ready;
  assign bus.data_o  = r_data;
  assign bus.valid_o = r_valid;

endmodule
